// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, runs the imem read handshake, buffers a
// fetched word across hazard stalls and drives the IF/ID write/flush strobes.
module fetch_stage #(
    parameter logic [31:0] PC_INIT = 32'h0000_0000,
    parameter int unsigned PC_STEP = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ihit,
    input  logic [31:0] imemload,
    output logic        imemREN,
    output logic [31:0] imemaddr,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_addr,
    input  logic        halt,
    output logic [31:0] ifinstr,
    output logic [31:0] ifJALjump_addr,
    output logic        ifW,
    output logic        ifRST
);

    localparam logic [31:0] Step = 32'(PC_STEP);

    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StHold,
        StHalted
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] pc_inc;

    // Link address doubles as the sequential next PC; wraps modulo 2^32.
    assign pc_inc         = pc_q + Step;
    assign imemaddr       = pc_q;
    assign ifJALjump_addr = pc_inc;

    // Next-state and combinational strobes; redirect/halt override the per-state action.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ibuf_d  = ibuf_q;
        imemREN = 1'b0;
        ifW     = 1'b0;
        ifRST   = 1'b0;
        ifinstr = 32'h0;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
            end
            StFetch: begin
                imemREN = 1'b1;
                ifinstr = imemload;
                if (ihit) begin
                    if (!stall) begin
                        ifW  = 1'b1;
                        pc_d = pc_inc;
                    end else begin
                        // Park the word; the PC stays on it until IF/ID accepts.
                        ibuf_d  = imemload;
                        state_d = StHold;
                    end
                end
            end
            StHold: begin
                ifinstr = ibuf_q;
                if (!stall) begin
                    ifW     = 1'b1;
                    pc_d    = pc_inc;
                    state_d = StFetch;
                end
            end
            StHalted: begin
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (state_q != StHalted) begin
            if (redirect) begin
                ifRST   = 1'b1;
                ifW     = 1'b0;
                pc_d    = {redirect_addr[31:2], 2'b00};
                ibuf_d  = 32'h0;
                state_d = StFetch;
            end else if (halt) begin
                ifRST   = 1'b1;
                ifW     = 1'b0;
                pc_d    = pc_q;
                ibuf_d  = 32'h0;
                state_d = StHalted;
            end
        end
    end

    // State registers; reset abandons any outstanding request.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= StIdle;
            pc_q    <= PC_INIT;
            ibuf_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ibuf_q  <= ibuf_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences and a randomized run against a behavioural reference model.
module tb_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST;
    logic        ihit;
    logic [31:0] imemload;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_addr;
    logic        halt;
    logic [31:0] ifinstr;
    logic [31:0] ifJALjump_addr;
    logic        ifW;
    logic        ifRST;

    int errors = 0;
    int checks = 0;

    fetch_stage #(
        .PC_INIT(32'h0000_0000),
        .PC_STEP(4)
    ) dut (
        .CLK           (CLK),
        .RST           (RST),
        .ihit          (ihit),
        .imemload      (imemload),
        .imemREN       (imemREN),
        .imemaddr      (imemaddr),
        .stall         (stall),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .halt          (halt),
        .ifinstr       (ifinstr),
        .ifJALjump_addr(ifJALjump_addr),
        .ifW           (ifW),
        .ifRST         (ifRST)
    );

    always #5 CLK = ~CLK;

    // Reference model: where the fetch unit "is", described by plain facts.
    logic [31:0] m_pc;        // address of the next word to fetch / word held
    logic        m_have_word; // a fetched word is waiting for IF/ID
    logic [31:0] m_word;
    logic        m_stopped;   // halted until reset
    logic        m_warmup;    // first cycle after reset, no request yet

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc        = 32'h0;
        m_have_word = 1'b0;
        m_word      = 32'h0;
        m_stopped   = 1'b0;
        m_warmup    = 1'b1;
    endtask

    task automatic model_check();
        logic        req, flush, wr;
        logic [31:0] instr;
        req   = !m_warmup && !m_stopped && !m_have_word;
        flush = !m_stopped && (redirect || halt);
        wr    = !m_stopped && !redirect && !halt && !stall && (m_have_word || (req && ihit));
        instr = m_have_word ? m_word : (req ? imemload : 32'h0);
        chk("m_imemREN", {31'h0, imemREN}, {31'h0, req});
        chk("m_imemaddr", imemaddr, m_pc);
        chk("m_jal", ifJALjump_addr, m_pc + 32'd4);
        chk("m_ifW", {31'h0, ifW}, {31'h0, wr});
        chk("m_ifRST", {31'h0, ifRST}, {31'h0, flush});
        chk("m_ifinstr", ifinstr, instr);
    endtask

    task automatic model_step();
        if (m_stopped) return;
        if (redirect) begin
            m_pc        = redirect_addr & ~32'd3;
            m_have_word = 1'b0;
            m_warmup    = 1'b0;
        end else if (halt) begin
            m_stopped   = 1'b1;
            m_have_word = 1'b0;
            m_warmup    = 1'b0;
        end else if (m_warmup) begin
            m_warmup = 1'b0;
        end else if (m_have_word) begin
            if (!stall) begin
                m_have_word = 1'b0;
                m_pc        = m_pc + 32'd4;
            end
        end else if (ihit) begin
            if (stall) begin
                m_have_word = 1'b1;
                m_word      = imemload;
            end else begin
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic drive(input logic ih, input logic st, input logic rd, input logic [31:0] rda,
                         input logic hl, input logic [31:0] ld);
        ihit          = ih;
        stall         = st;
        redirect      = rd;
        redirect_addr = rda;
        halt          = hl;
        imemload      = ld;
    endtask

    // One model-checked cycle: drive at negedge, compare, advance on posedge.
    task automatic cycle(input logic ih, input logic st, input logic rd, input logic [31:0] rda,
                         input logic hl, input logic [31:0] ld);
        @(negedge CLK);
        drive(ih, st, rd, rda, hl, ld);
        #1;
        model_check();
        @(posedge CLK);
        model_step();
    endtask

    // Reset held across one posedge, with literal reset-value checks.
    task automatic do_reset();
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        RST = 1'b1;
        #1;
        chk("rst_imemREN", {31'h0, imemREN}, 32'h0);
        chk("rst_ifW", {31'h0, ifW}, 32'h0);
        chk("rst_ifRST", {31'h0, ifRST}, 32'h0);
        chk("rst_ifinstr", ifinstr, 32'h0);
        chk("rst_imemaddr", imemaddr, 32'h0);
        chk("rst_jal", ifJALjump_addr, 32'h4);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic        ih, st, rd, hl;
        logic [31:0] rda, ld;
        logic        ew, er, eren;
        logic [31:0] eaddr, ejal, einstr;
    } vec_t;

    vec_t tbl[14];

    initial begin
        RST = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        model_reset();

        // Directed table from reset: stall/hold, redirect while waiting, redirect in HOLD, halt.
        tbl[0]  = '{1, 0, 0, 0, 32'h0,   32'hA000_0000, 0, 0, 0, 32'h0,   32'h4,   32'h0};
        tbl[1]  = '{1, 0, 0, 0, 32'h0,   32'hA000_0001, 1, 0, 1, 32'h0,   32'h4,   32'hA000_0001};
        tbl[2]  = '{1, 1, 0, 0, 32'h0,   32'h2001_0005, 0, 0, 1, 32'h4,   32'h8,   32'h2001_0005};
        tbl[3]  = '{1, 1, 0, 0, 32'h0,   32'hDEAD_BEEF, 0, 0, 0, 32'h4,   32'h8,   32'h2001_0005};
        tbl[4]  = '{1, 1, 0, 0, 32'h0,   32'hDEAD_BEEF, 0, 0, 0, 32'h4,   32'h8,   32'h2001_0005};
        tbl[5]  = '{0, 0, 0, 0, 32'h0,   32'hDEAD_BEEF, 1, 0, 0, 32'h4,   32'h8,   32'h2001_0005};
        tbl[6]  = '{0, 1, 0, 0, 32'h0,   32'h1111_1111, 0, 0, 1, 32'h8,   32'hC,   32'h1111_1111};
        tbl[7]  = '{0, 0, 1, 0, 32'h103, 32'h2222_2222, 0, 1, 1, 32'h8,   32'hC,   32'h2222_2222};
        tbl[8]  = '{1, 1, 0, 0, 32'h0,   32'h55,        0, 0, 1, 32'h100, 32'h104, 32'h55};
        tbl[9]  = '{1, 1, 1, 0, 32'h200, 32'h66,        0, 1, 0, 32'h100, 32'h104, 32'h55};
        tbl[10] = '{1, 0, 0, 0, 32'h0,   32'h77,        1, 0, 1, 32'h200, 32'h204, 32'h77};
        tbl[11] = '{1, 0, 0, 1, 32'h0,   32'h88,        0, 1, 1, 32'h204, 32'h208, 32'h88};
        tbl[12] = '{1, 0, 0, 0, 32'h0,   32'h99,        0, 0, 0, 32'h204, 32'h208, 32'h0};
        tbl[13] = '{1, 0, 1, 0, 32'h300, 32'h99,        0, 0, 0, 32'h204, 32'h208, 32'h0};

        do_reset();
        for (int i = 0; i < 14; i++) begin
            @(negedge CLK);
            drive(tbl[i].ih, tbl[i].st, tbl[i].rd, tbl[i].rda, tbl[i].hl, tbl[i].ld);
            #1;
            chk($sformatf("v%0d_ifW", i), {31'h0, ifW}, {31'h0, tbl[i].ew});
            chk($sformatf("v%0d_ifRST", i), {31'h0, ifRST}, {31'h0, tbl[i].er});
            chk($sformatf("v%0d_imemREN", i), {31'h0, imemREN}, {31'h0, tbl[i].eren});
            chk($sformatf("v%0d_imemaddr", i), imemaddr, tbl[i].eaddr);
            chk($sformatf("v%0d_jal", i), ifJALjump_addr, tbl[i].ejal);
            chk($sformatf("v%0d_ifinstr", i), ifinstr, tbl[i].einstr);
        end

        // Halted stays quiet, reset brings the PC home.
        do_reset();

        // Streaming fetch with ihit tied high: one idle cycle, then a write every cycle.
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, imemaddr ^ 32'h5A5A_0000);
            #1;
            model_check();
            if (i > 0) chk("stream_addr", imemaddr, 32'(4 * (i - 1)));
            @(posedge CLK);
            model_step();
        end

        // PC wrap at the top of the address space.
        do_reset();
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0);
        @(negedge CLK);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'hCAFE_0001);
        #1;
        chk("wrap_addr", imemaddr, 32'hFFFF_FFFC);
        chk("wrap_jal", ifJALjump_addr, 32'h0);
        chk("wrap_ifW", {31'h0, ifW}, 32'h1);
        @(posedge CLK);
        model_step();
        @(negedge CLK);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("wrap_next_addr", imemaddr, 32'h0);
        chk("wrap_ren", {31'h0, imemREN}, 32'h1);

        // Asynchronous reset mid-FETCH, no clock edge in between.
        ihit = 1'b1;
        #1;
        RST = 1'b1;
        #1;
        chk("async_imemREN", {31'h0, imemREN}, 32'h0);
        chk("async_ifW", {31'h0, ifW}, 32'h0);
        chk("async_ifinstr", ifinstr, 32'h0);
        chk("async_imemaddr", imemaddr, 32'h0);
        chk("async_jal", ifJALjump_addr, 32'h4);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        model_reset();

        // Randomized run against the model, with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 3) != 0),
                      ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 15) == 0),
                      $urandom,
                      ($urandom_range(0, 99) == 0),
                      $urandom);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
